// File: rtl/muldiv_unit_pkg.sv
// Shared RV32M constants and FSM state encodings for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Divide/remainder codes all have funct3[2] set.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational sign correction and special-case selection of the final RV32M result.
module muldiv_sign_fix
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] prod,
  input  logic [XLEN-1:0]   quo,
  input  logic [XLEN-1:0]   rem,
  input  logic              sign_a,
  input  logic              sign_b,
  input  logic              div_zero,
  input  logic              overflow,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   result
);

  logic              neg_res;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  always_comb begin
    neg_res = sign_a ^ sign_b;
    prod_s  = neg_res ? -prod : prod;
    quo_s   = neg_res ? -quo  : quo;
    rem_s   = sign_a  ? -rem  : rem;
    result  = '0;
    unique case (funct3)
      F3_MUL:                        result = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU: begin
        if (div_zero)      result = '1;
        else if (overflow) result = {1'b1, {(XLEN-1){1'b0}}};
        else               result = quo_s;
      end
      // Divide-by-zero leaves the dividend magnitude in rem, so REM/REMU return op_a here.
      F3_REM, F3_REMU:               result = overflow ? '0 : rem_s;
      default:                       result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps, then a sign-fix cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  logic [1:0]      state;
  logic [4:0]      cnt;
  logic [2:0]      f3_q;
  logic            sign_a_q, sign_b_q, div_zero_q, ovf_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] result_q;

  logic            sign_a, sign_b, is_div, div_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_trial;
  logic            div_ge;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    sign_a   = bus.op_a[XLEN-1] &
               (bus.funct3 == F3_MULH || bus.funct3 == F3_MULHSU ||
                bus.funct3 == F3_DIV  || bus.funct3 == F3_REM);
    sign_b   = bus.op_b[XLEN-1] &
               (bus.funct3 == F3_MULH || bus.funct3 == F3_DIV || bus.funct3 == F3_REM);
    mag_a    = sign_a ? -bus.op_a : bus.op_a;
    mag_b    = sign_b ? -bus.op_b : bus.op_b;
    is_div   = f3_is_div(bus.funct3);
    div_zero = (bus.op_b == '0);
    ovf      = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM) &&
               (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
  end

  // hi/lo are shared: product {hi,lo} for multiply, remainder/quotient for divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_trial = div_shift[XLEN-1:0] - opnd_q;
  end

  muldiv_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .prod    ({hi_q, lo_q}),
    .quo     (lo_q),
    .rem     (hi_q),
    .sign_a  (sign_a_q),
    .sign_b  (sign_b_q),
    .div_zero(div_zero_q),
    .overflow(ovf_q),
    .funct3  (f3_q),
    .result  (fix_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            f3_q       <= bus.funct3;
            sign_a_q   <= sign_a;
            sign_b_q   <= sign_b;
            div_zero_q <= div_zero;
            ovf_q      <= ovf;
            opnd_q     <= is_div ? mag_b : mag_a;
            lo_q       <= is_div ? mag_a : mag_b;
            hi_q       <= '0;
            cnt        <= '0;
            state      <= ST_CALC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (f3_is_div(f3_q)) begin
            hi_q <= div_ge ? div_trial : div_shift[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], div_ge};
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == '1) state <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= fix_result;
          state    <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == ST_CALC) || (state == ST_FIX);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result_q;

endmodule
